rect_engine: RTL and testbench
==============================

// Module: rect_engine
// PURPOSE
//  Parametrised rectangle rasteriser for the VGA plot path: the next generation of the
//  rectangle drawer. Accepts a start/geometry/colour command, emits one pixel
//  coordinate per accepted beat with valid/ready backpressure, and supports fill and
//  outline modes, screen-edge clipping, abort and a one-cycle done pulse. Sits between
//  game-object FSMs and the VGA adapter write port (plot = pix_valid & pix_ready).
// PARAMETERS
//  COORD_W   8    width of x/y coordinates and of width/height fields
//  COLOUR_W  3    width of colour bus
//  SCREEN_W  160  pixels with x >= SCREEN_W are clipped (never emitted)
//  SCREEN_H  120  pixels with y >= SCREEN_H are clipped (never emitted)
// PORTS
//  clk         in   1         system clock, rising edge
//  resetn      in   1         asynchronous active-low reset
//  start       in   1         command strobe; sampled only in IDLE
//  abort       in   1         synchronous abort; return to IDLE, no done pulse
//  mode        in   1         0 = filled rectangle, 1 = outline only
//  start_x     in   COORD_W   top-left x
//  start_y     in   COORD_W   top-left y
//  width       in   COORD_W   rectangle width in pixels (0 = empty)
//  height      in   COORD_W   rectangle height in pixels (0 = empty)
//  colour_in   in   COLOUR_W  pixel colour
//  pix_ready   in   1         downstream accepts pixel this cycle
//  pix_valid   out  1         x_out/y_out/colour_out hold a pixel to write
//  x_out       out  COORD_W   pixel x
//  y_out       out  COORD_W   pixel y
//  colour_out  out  COLOUR_W  pixel colour
//  busy        out  1         high in DRAW state
//  done        out  1         one-cycle pulse after last pixel accepted
// BEHAVIOUR
//  Reset (resetn=0, any time incl. mid-draw): state=IDLE; all outputs 0; counters 0.
//  States: IDLE -> DRAW on start; DRAW -> DONE after last pixel; DONE -> IDLE (1 cycle);
//   abort in DRAW or DONE -> IDLE next edge, done not asserted; abort has priority.
//  IDLE: on start latch start_x/y, width, height, colour_in, mode; dx=dy=0.
//   width==0 or height==0 -> go straight to DONE (no pixels, done still pulses).
//  start while busy/DONE is ignored; geometry inputs may change freely after latch.
//  DRAW scan: row-major, dx 0..w-1 inner, dy 0..h-1 outer; x=sx+dx, y=sy+dy.
//  Sums computed COORD_W+1 wide; carry set or x>=SCREEN_W or y>=SCREEN_H => clipped.
//  Outline: pixel emitted only if dx==0, dx==w-1, dy==0 or dy==h-1; on interior
//   rows dx jumps 0 -> w-1 (no cycles spent on interior). w==1 or h==1 -> same as fill.
//  Candidate pixel emitted (pix_valid=1) unless clipped; clipped candidates advance in
//   one cycle with pix_valid=0.
//  Handshake: counters advance only on pix_valid & pix_ready (or clipped candidate).
//   While pix_valid & !pix_ready, x_out/y_out/colour_out/pix_valid held stable.
//  Latency: start at edge N -> first pix_valid at N+1; full-ready fill of w*h pixels
//   occupies w*h DRAW cycles; done high in cycle after last accept, busy low then.
//  Outputs registered; pix_valid=0 and busy=0 outside DRAW.
// TESTING
//  Fill 3x2 at (10,20), ready=1 -> 6 pixels (10..12,20),(10..12,21) in order, done@N+7.
//  Outline 4x3 at (0,0) -> 10 pixels, interior (1..2,1) never emitted.
//  Fill 4x1 at (158,5), SCREEN_W=160 -> only (158,5),(159,5) emitted; done still pulses.
//  Random pix_ready stall during 5x5 fill -> outputs stable while stalled, 25 unique pixels.
//  width=0 -> no pix_valid, done one cycle after start; start while busy ignored.
//  abort or resetn low mid-draw -> IDLE, pix_valid=0, no done; next start draws fully.

Source files
------------

// File: rtl/rect_engine.sv
// rect_engine: rectangle rasteriser with fill/outline modes, screen clipping, abort and valid/ready pixel output
module rect_engine #(
   parameter int COORD_W  = 8,
   parameter int COLOUR_W = 3,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic                abort,
   input  logic                mode,
   input  logic [COORD_W-1:0]  start_x,
   input  logic [COORD_W-1:0]  start_y,
   input  logic [COORD_W-1:0]  width,
   input  logic [COORD_W-1:0]  height,
   input  logic [COLOUR_W-1:0] colour_in,
   input  logic                pix_ready,
   output logic                pix_valid,
   output logic [COORD_W-1:0]  x_out,
   output logic [COORD_W-1:0]  y_out,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                busy,
   output logic                done
);
   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
   localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(SCREEN_W);
   localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(SCREEN_H);
   state_t state;
   logic [COORD_W-1:0] sx, sy, w, h, dx, dy, wm1, hm1, ndx, ndy;
   logic [COORD_W:0] nx, ny;
   logic outline, last, nclip;
   function automatic logic clip(input logic [COORD_W:0] x, input logic [COORD_W:0] y);
      return x[COORD_W] | y[COORD_W] | (x >= X_LIM) | (y >= Y_LIM);
   endfunction
   // next candidate in row-major order; outline interior rows jump straight from the left to the right edge
   always_comb begin
      wm1   = w - 1'b1;
      hm1   = h - 1'b1;
      last  = (dx == wm1) && (dy == hm1);
      ndx   = (dx == wm1) ? '0 :
              (outline && dx == '0 && dy != '0 && dy != hm1) ? wm1 : dx + 1'b1;
      ndy   = (dx == wm1) ? dy + 1'b1 : dy;
      nx    = {1'b0, sx} + {1'b0, ndx};
      ny    = {1'b0, sy} + {1'b0, ndy};
      nclip = clip(nx, ny);
   end
   // command latch, scan sequencing and registered pixel outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         sx         <= '0;
         sy         <= '0;
         w          <= '0;
         h          <= '0;
         dx         <= '0;
         dy         <= '0;
         outline    <= 1'b0;
         pix_valid  <= 1'b0;
         x_out      <= '0;
         y_out      <= '0;
         colour_out <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (abort && state != IDLE) begin
         state     <= IDLE;
         pix_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               sx         <= start_x;
               sy         <= start_y;
               w          <= width;
               h          <= height;
               outline    <= mode;
               dx         <= '0;
               dy         <= '0;
               x_out      <= start_x;
               y_out      <= start_y;
               colour_out <= colour_in;
               if (width == '0 || height == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state     <= DRAW;
                  busy      <= 1'b1;
                  pix_valid <= !clip({1'b0, start_x}, {1'b0, start_y});
               end
            end
            DRAW: if (!pix_valid || pix_ready) begin
               if (last) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  pix_valid <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  dx        <= ndx;
                  dy        <= ndy;
                  x_out     <= nx[COORD_W-1:0];
                  y_out     <= ny[COORD_W-1:0];
                  pix_valid <= !nclip;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rect_engine.sv
// tb_rect_engine: directed self-checking bench for rect_engine against a pixel-list model
module tb_rect_engine;
   logic clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0, mode = 1'b0, pix_ready = 1'b0;
   logic [7:0] start_x = '0, start_y = '0, width = '0, height = '0, x_out, y_out;
   logic [2:0] colour_in = '0, colour_out;
   logic pix_valid, busy, done;
   typedef struct {int x; int y; int c;} pix_t;
   pix_t expq[$];
   int checks = 0, errors = 0, done_seen = 0;
   logic hold_chk = 1'b0;
   logic [7:0] hx, hy;
   logic [2:0] hc;

   rect_engine dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort), .mode(mode),
      .start_x(start_x), .start_y(start_y), .width(width), .height(height),
      .colour_in(colour_in), .pix_ready(pix_ready), .pix_valid(pix_valid),
      .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=no-event", name);
   endtask

   // expected accepted pixels: every rectangle cell, outline keeps only border cells, off-screen cells dropped
   task automatic build(input int sx, input int sy, input int w, input int h, input int m, input int c);
      expq.delete();
      for (int j = 0; j < h; j++)
         for (int i = 0; i < w; i++) begin
            if (m == 1 && !(i == 0 || i == w - 1 || j == 0 || j == h - 1)) continue;
            if (sx + i < 160 && sy + j < 120) expq.push_back('{sx + i, sy + j, c});
         end
   endtask

   // per-cycle compare: stall stability, accepted pixels against model order, done/busy exclusivity
   always @(negedge clk) begin
      pix_t p;
      if (hold_chk) begin
         chk("hold_valid", pix_valid, 1);
         chk("hold_x", x_out, hx);
         chk("hold_y", y_out, hy);
         chk("hold_colour", colour_out, hc);
      end
      if (pix_valid) begin
         chk("valid_busy", busy, 1);
         if (pix_ready) begin
            if (expq.size() == 0) fail("extra_pix");
            else begin
               p = expq.pop_front();
               chk("pix_x", x_out, p.x);
               chk("pix_y", y_out, p.y);
               chk("pix_colour", colour_out, p.c);
            end
         end
      end
      if (done) begin
         done_seen++;
         chk("done_busy", busy, 0);
      end
      hold_chk = pix_valid && !pix_ready && !abort && resetn;
      hx = x_out;
      hy = y_out;
      hc = colour_out;
   end

   task automatic issue(input int sx, input int sy, input int w, input int h, input int m, input int c);
      @(posedge clk);
      #1;
      start_x = 8'(sx); start_y = 8'(sy); width = 8'(w); height = 8'(h);
      mode = m[0]; colour_in = 3'(c); start = 1'b1;
      build(sx, sy, w, h, m, c);
   endtask

   // cycle 0 holds start; exp_done/exp_first are cycle indices, -2 skips, -1 means never
   task automatic run_cmd(input int sx, input int sy, input int w, input int h, input int m, input int c,
                          input bit rnd, input bit poke, input int exp_done, input int exp_first);
      int first = -1, dcyc = -1, d0;
      d0 = done_seen;
      issue(sx, sy, w, h, m, c);
      for (int cyc = 1; cyc < 2000; cyc++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke && cyc == 2) begin
            start = 1'b1; start_x = 8'd77; start_y = 8'd3; width = 8'd1; height = 8'd1;
         end
         if (poke && cyc == 3) start_x = 8'd90;
         @(negedge clk);
         if (pix_valid && first < 0) first = cyc;
         if (done) begin
            dcyc = cyc;
            break;
         end
      end
      if (dcyc < 0) fail("timeout");
      if (exp_done != -2) chk("done_cycle", dcyc, exp_done);
      if (exp_first != -2) chk("first_valid", first, exp_first);
      chk("queue_drained", expq.size(), 0);
      @(negedge clk);
      chk("done_pulse_low", done, 0);
      chk("idle_valid", pix_valid, 0);
      chk("done_pulses", done_seen - d0, 1);
   endtask

   task automatic kill_test(input bit use_reset);
      int d0;
      issue(1, 1, 5, 5, 0, 4);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         pix_ready = 1'b1;
      end
      d0 = done_seen;
      if (use_reset) begin
         resetn = 1'b0;
         #1;
         chk("async_rst_valid", pix_valid, 0);
         chk("async_rst_busy", busy, 0);
         chk("async_rst_x", x_out, 0);
      end else abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      resetn = 1'b1;
      expq.delete();
      @(negedge clk);
      chk(use_reset ? "rst_valid" : "abort_valid", pix_valid, 0);
      chk(use_reset ? "rst_busy" : "abort_busy", busy, 0);
      repeat (10) @(negedge clk);
      chk(use_reset ? "rst_no_done" : "abort_no_done", done_seen - d0, 0);
   endtask

   initial begin
      int hits;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", pix_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_x", x_out, 0);
      chk("rst_y", y_out, 0);
      chk("rst_colour", colour_out, 0);
      #1 resetn = 1'b1;
      build(10, 20, 3, 2, 0, 5);
      chk("model_fill_n", expq.size(), 6);
      chk("model_fill_x0", expq[0].x, 10);
      chk("model_fill_y0", expq[0].y, 20);
      chk("model_fill_x5", expq[5].x, 12);
      chk("model_fill_y5", expq[5].y, 21);
      build(0, 0, 4, 3, 1, 1);
      chk("model_outline_n", expq.size(), 10);
      hits = 0;
      foreach (expq[i]) if (expq[i].y == 1 && (expq[i].x == 1 || expq[i].x == 2)) hits++;
      chk("model_outline_interior", hits, 0);
      build(158, 5, 4, 1, 0, 2);
      chk("model_clip_n", expq.size(), 2);
      chk("model_clip_x1", expq[1].x, 159);
      run_cmd(10, 20, 3, 2, 0, 5, 0, 0, 7, 1);
      run_cmd(0, 0, 4, 3, 1, 1, 0, 0, 11, 1);
      run_cmd(158, 5, 4, 1, 0, 2, 0, 0, 5, 1);
      run_cmd(200, 5, 3, 1, 0, 3, 0, 0, 4, -1);
      run_cmd(100, 118, 2, 4, 0, 6, 0, 0, 9, 1);
      run_cmd(30, 40, 5, 5, 0, 6, 1, 0, -2, 1);
      run_cmd(20, 30, 6, 5, 1, 7, 1, 0, -2, 1);
      run_cmd(7, 7, 1, 3, 1, 3, 0, 0, 4, 1);
      run_cmd(5, 5, 0, 4, 0, 1, 0, 0, 1, -1);
      run_cmd(5, 5, 4, 0, 0, 1, 0, 0, 1, -1);
      run_cmd(60, 70, 3, 3, 0, 2, 0, 1, 10, 1);
      kill_test(0);
      run_cmd(1, 1, 2, 2, 0, 4, 0, 0, 5, 1);
      kill_test(1);
      run_cmd(3, 4, 3, 3, 1, 5, 0, 0, 9, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
